// File: rtl/comperator_sad_worker_pkg.sv
// Shared definitions for the comparator disparity-search workers: FSM states,
// SAD width helper and default geometry used by the controller's top level.
package comperator_pkg;

    localparam int DEF_PIX_W    = 8;
    localparam int DEF_WIN      = 8;
    localparam int DEF_MAX_DISP = 16;
    localparam int DEF_ADDR_W   = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_FINISH  = 3'd4
    } sad_state_t;

    // Accumulating WIN absolute differences of PIX_W-bit pixels needs
    // $clog2(WIN) extra bits to be overflow-free.
    function automatic int sad_width(input int pix_w, input int win);
        return pix_w + $clog2(win);
    endfunction

endpackage

// File: rtl/comperator_sad_worker_accum.sv
// Registered absolute-difference accumulator: clr zeroes the sum, en adds
// |a - b| to it. Clear has priority over enable.
module comperator_sad_accum
    import comperator_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int SAD_W = sad_width(DEF_PIX_W, DEF_WIN)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clr,
    input  logic             en,
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    output logic [SAD_W-1:0] acc
);

    logic [PIX_W-1:0] diff_s;
    logic [SAD_W-1:0] acc_r;

    // Unsigned absolute difference of the two pixels
    always_comb begin
        diff_s = {PIX_W{1'b0}};
        if (a >= b) begin
            diff_s = a - b;
        end else begin
            diff_s = b - a;
        end
    end

    // Accumulator register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_r <= {SAD_W{1'b0}};
        end else if (clr) begin
            acc_r <= {SAD_W{1'b0}};
        end else if (en) begin
            acc_r <= acc_r + SAD_W'(diff_s);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/comperator_sad_worker.sv
// Disparity-search worker: per go, scans MAX_DISP candidate shifts and reports
// the minimum-SAD disparity. Optional threshold flag under COMP_SAD_THRESH_EN.
module comperator_sad_worker
    import comperator_pkg::*;
#(
    parameter int PIX_W    = DEF_PIX_W,
    parameter int WIN      = DEF_WIN,
    parameter int MAX_DISP = DEF_MAX_DISP,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int SAD_W    = sad_width(PIX_W, WIN),
    parameter int DISP_W   = $clog2(MAX_DISP)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              go,
    input  logic [ADDR_W-1:0] base_addr,
`ifdef COMP_SAD_THRESH_EN
    input  logic [SAD_W-1:0]  sad_thresh,
    output logic              disp_valid,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] l_addr,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [PIX_W-1:0]  l_data,
    input  logic [PIX_W-1:0]  r_data,
    output logic [DISP_W-1:0] disparity,
    output logic [SAD_W-1:0]  best_sad,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(WIN);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WIN - 1);
    localparam logic [DISP_W-1:0] D_LAST   = DISP_W'(MAX_DISP - 1);

    sad_state_t        state_r, state_nx_s;
    logic [IDX_W-1:0]  idx_r, idx_nx_s;
    logic [DISP_W-1:0] d_r, d_nx_s;
    logic [ADDR_W-1:0] base_r, base_nx_s;
    logic              start_s, clr_s, fin_s;
    logic              valid_r;
    logic [SAD_W-1:0]  acc_s;
    logic [SAD_W-1:0]  best_r, best_nx_s;
    logic [DISP_W-1:0] disp_r, disp_nx_s;
    logic              rd_en_r, busy_r, done_r;
    logic [ADDR_W-1:0] l_addr_r, r_addr_r;

    // Next-state and counter logic
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        d_nx_s     = d_r;
        base_nx_s  = base_r;
        start_s    = 1'b0;
        clr_s      = 1'b0;
        fin_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_FINISH: begin
                if (go) begin
                    start_s    = 1'b1;
                    clr_s      = 1'b1;
                    base_nx_s  = base_addr;
                    idx_nx_s   = {IDX_W{1'b0}};
                    d_nx_s     = {DISP_W{1'b0}};
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (idx_r == IDX_LAST) begin
                    idx_nx_s   = {IDX_W{1'b0}};
                    state_nx_s = ST_DRAIN;
                end else begin
                    idx_nx_s   = idx_r + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                state_nx_s = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (d_r == D_LAST) begin
                    fin_s      = 1'b1;
                    state_nx_s = ST_FINISH;
                end else begin
                    clr_s      = 1'b1;
                    d_nx_s     = d_r + DISP_W'(1);
                    state_nx_s = ST_ISSUE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Best-so-far tracking; strict compare keeps the lower disparity on ties
    always_comb begin
        best_nx_s = best_r;
        disp_nx_s = disp_r;
        if (start_s) begin
            best_nx_s = {SAD_W{1'b1}};
        end else if ((state_r == ST_COMPARE) && (acc_s < best_r)) begin
            best_nx_s = acc_s;
            disp_nx_s = d_r;
        end else begin
            best_nx_s = best_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r  <= ST_IDLE;
            idx_r    <= {IDX_W{1'b0}};
            d_r      <= {DISP_W{1'b0}};
            base_r   <= {ADDR_W{1'b0}};
            valid_r  <= 1'b0;
            best_r   <= {SAD_W{1'b0}};
            disp_r   <= {DISP_W{1'b0}};
            rd_en_r  <= 1'b0;
            l_addr_r <= {ADDR_W{1'b0}};
            r_addr_r <= {ADDR_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            idx_r    <= idx_nx_s;
            d_r      <= d_nx_s;
            base_r   <= base_nx_s;
            valid_r  <= rd_en_r;
            best_r   <= best_nx_s;
            disp_r   <= disp_nx_s;
            rd_en_r  <= (state_nx_s == ST_ISSUE);
            // Right address wraps modulo 2^ADDR_W by design
            l_addr_r <= base_nx_s + ADDR_W'(idx_nx_s);
            r_addr_r <= base_nx_s + ADDR_W'(idx_nx_s) - ADDR_W'(d_nx_s);
            busy_r   <= (state_nx_s == ST_ISSUE) || (state_nx_s == ST_DRAIN) ||
                        (state_nx_s == ST_COMPARE);
            if (start_s) begin
                done_r <= 1'b0;
            end else if (fin_s) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end
        end
    end

    comperator_sad_accum #(
        .PIX_W (PIX_W),
        .SAD_W (SAD_W)
    ) u_accum (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clr     (clr_s),
        .en      (valid_r),
        .a       (l_data),
        .b       (r_data),
        .acc     (acc_s)
    );

`ifdef COMP_SAD_THRESH_EN
    logic [SAD_W-1:0] thresh_r;
    logic             disp_valid_r;

    // Threshold capture with go, verdict registered as the search finishes
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            thresh_r     <= {SAD_W{1'b0}};
            disp_valid_r <= 1'b0;
        end else if (start_s) begin
            thresh_r     <= sad_thresh;
            disp_valid_r <= 1'b0;
        end else if (fin_s) begin
            disp_valid_r <= (best_nx_s <= thresh_r);
        end else begin
            disp_valid_r <= disp_valid_r;
        end
    end

    assign disp_valid = disp_valid_r;
`endif

    assign rd_en     = rd_en_r;
    assign l_addr    = l_addr_r;
    assign r_addr    = r_addr_r;
    assign disparity = disp_r;
    assign best_sad  = best_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_comperator_sad_worker.sv
// Directed bench for comperator_sad_worker with a 1-cycle-latency RAM model;
// exercises the threshold flag too when COMP_SAD_THRESH_EN is defined.
module tb_comperator_sad_worker;

    localparam int ADDR_W = 10;
    localparam int SAD_W  = 11;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              go = 1'b0;
    logic [ADDR_W-1:0] base_addr = 10'd0;
    logic              rd_en;
    logic [ADDR_W-1:0] l_addr, r_addr;
    logic [7:0]        l_data = 8'd0;
    logic [7:0]        r_data = 8'd0;
    logic [3:0]        disparity;
    logic [SAD_W-1:0]  best_sad;
    logic              busy, done;
`ifdef COMP_SAD_THRESH_EN
    logic [SAD_W-1:0]  sad_thresh = 11'd0;
    logic              disp_valid;
`endif

    logic [7:0] lmem [0:1023];
    logic [7:0] rmem [0:1023];
    int total = 0;
    int bad = 0;
    int lat;

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (rd_en) begin
            l_data <= lmem[l_addr];
            r_data <= rmem[r_addr];
        end
    end

    comperator_sad_worker dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .go        (go),
        .base_addr (base_addr),
`ifdef COMP_SAD_THRESH_EN
        .sad_thresh(sad_thresh),
        .disp_valid(disp_valid),
`endif
        .rd_en     (rd_en),
        .l_addr    (l_addr),
        .r_addr    (r_addr),
        .l_data    (l_data),
        .r_data    (r_data),
        .disparity (disparity),
        .best_sad  (best_sad),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) begin
            lmem[i] = 8'd0;
            rmem[i] = 8'd0;
        end
    endtask

    // Pulse go, then count edges after the sampling edge until done rises.
    task automatic run_search(input logic [ADDR_W-1:0] b, output int n);
        @(negedge aclk);
        go = 1'b1;
        base_addr = b;
        @(posedge aclk);
        #1;
        go = 1'b0;
        check("done_cleared_on_go", {31'd0, done}, 32'd0);
        check("busy_after_go", {31'd0, busy}, 32'd1);
        n = 0;
        while (n < 400) begin
            @(posedge aclk);
            n++;
            #1;
            if (done) break;
        end
        if (n >= 400) begin
            bad++;
            $error("FAIL timeout: done not seen within %0d cycles", n);
        end
    endtask

    // Shifted pattern: R[base+i-3] = L[base+i], distinct rising values.
    task automatic load_shift3();
        clear_mem();
        for (int i = 0; i < 8; i++) begin
            lmem[100 + i] = 8'(20 + 13 * i);
            rmem[97 + i]  = 8'(20 + 13 * i);
        end
    endtask

    initial begin
        #2;
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_disparity", {28'd0, disparity}, 32'd0);
        check("rst_best_sad", {21'd0, best_sad}, 32'd0);
        #20;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);

        // 1: shift of 3, latency 160
        load_shift3();
        run_search(10'd100, lat);
        check("t1_latency", lat, 32'd160);
        check("t1_disparity", {28'd0, disparity}, 32'd3);
        check("t1_best_sad", {21'd0, best_sad}, 32'd0);
        check("t1_busy_low", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge aclk);
        #1;
        check("t1_done_held", {31'd0, done}, 32'd1);
        check("t1_disp_stable", {28'd0, disparity}, 32'd3);

        // 2: all zero pixels, every SAD ties
        clear_mem();
        run_search(10'd100, lat);
        check("t2_disparity", {28'd0, disparity}, 32'd0);
        check("t2_best_sad", {21'd0, best_sad}, 32'd0);

        // 3: L=255, R=0 gives 8*255 everywhere
        clear_mem();
        for (int i = 0; i < 1024; i++) lmem[i] = 8'd255;
        run_search(10'd300, lat);
        check("t3_disparity", {28'd0, disparity}, 32'd0);
        check("t3_best_sad", {21'd0, best_sad}, 32'd2040);

        // 4: base 2, shift 5, right reads wrap to 1021..1023
        clear_mem();
        for (int i = 0; i < 8; i++) begin
            lmem[2 + i] = 8'(40 + 7 * i);
            rmem[(1024 + 2 + i - 5) % 1024] = 8'(40 + 7 * i);
        end
        run_search(10'd2, lat);
        check("t4_latency", lat, 32'd160);
        check("t4_disparity", {28'd0, disparity}, 32'd5);
        check("t4_best_sad", {21'd0, best_sad}, 32'd0);

        // 5: go at cycle 40 ignored, reset at cycle 50, then a clean rerun
        load_shift3();
        @(negedge aclk);
        go = 1'b1;
        base_addr = 10'd100;
        @(posedge aclk);
        #1;
        go = 1'b0;
        repeat (38) @(posedge aclk);
        @(negedge aclk);
        go = 1'b1;
        base_addr = 10'd500;
        @(posedge aclk);
        #1;
        go = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        check("t5_busy_kept", {31'd0, busy}, 32'd1);
        check("t5_laddr_range", {31'd0, (l_addr >= 10'd100) && (l_addr <= 10'd107)}, 32'd1);
        repeat (4) @(posedge aclk);
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        check("t5_rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_done", {31'd0, done}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        run_search(10'd100, lat);
        check("t5_latency", lat, 32'd160);
        check("t5_disparity", {28'd0, disparity}, 32'd3);
        check("t5_best_sad", {21'd0, best_sad}, 32'd0);

`ifdef COMP_SAD_THRESH_EN
        // 6: uniform SAD of 8*15=120 against thresholds 100 and 120
        clear_mem();
        for (int i = 0; i < 1024; i++) lmem[i] = 8'd15;
        sad_thresh = 11'd100;
        run_search(10'd200, lat);
        check("t6_best_sad", {21'd0, best_sad}, 32'd120);
        check("t6_valid_below", {31'd0, disp_valid}, 32'd0);
        sad_thresh = 11'd120;
        run_search(10'd200, lat);
        check("t6_valid_equal", {31'd0, disp_valid}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
